arith_update_sequencer: RTL
===========================

Name: arith_update_sequencer

Overview:
Parametrised successor to the two-diagonal arithmetic controller. On each start it computes per-lane deltas with the shared external subtractor: delta[l] = element[l] - new_element[l]. It then drives the shared external adder to produce new_diag[d][l] = diag_in[d][l] + delta[l] for every diagonal d. It sits between the element-update logic and the shared sub/add datapath units, and supports multi-word elements, any number of diagonals, latency-parametrised arithmetic units, and a zero-delta fast path.

Parameters:
WORD_W, 24, width of one lane word (arith unit width)
LANES, 2, words per element/diagonal; lane LANES-1 is the most-significant word
NUM_DIAG, 2, number of diagonal accumulators updated per start
ARITH_LAT, 0, cycles from arith-unit inputs to valid output (0 = combinational)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  request; accepted only in IDLE
element  in  LANES*WORD_W  old element value
new_element  in  LANES*WORD_W  new element value
diag_in  in  NUM_DIAG*LANES*WORD_W  current diagonals; diag d occupies bits [(d+1)*LANES*WORD_W-1 : d*LANES*WORD_W]
sub_a  out  WORD_W  subtractor minuend
sub_b  out  WORD_W  subtractor subtrahend
sub_y  in  WORD_W  subtractor result
add_a  out  WORD_W  adder operand (diagonal word)
add_b  out  WORD_W  adder operand (delta word)
add_y  in  WORD_W  adder result
new_diag  out  NUM_DIAG*LANES*WORD_W  updated diagonals, same packing as diag_in
diag_done  out  NUM_DIAG  per-diagonal complete flag, sticky until next accepted start
busy  out  1  high in SUB/ADD
done  out  1  one-cycle pulse in DONE

Behaviour:
- Clock is clock, reset is reset: synchronous, active-high.
- Reset values: new_diag=0, diag_done=0, busy=0, done=0, state=IDLE, all internal counters/delta regs 0. Arith inputs drive 0 when not in use (never X).
- Reset mid-operation aborts immediately. No partial results are retained.
- States: IDLE, SUB, ADD, DONE.
- IDLE + start (sampled at edge t): capture element, new_element and diag_in into internal registers, and clear diag_done. Inputs may change after t.
  - If captured element == new_element: go to DONE (fast path) with new_diag <= diag_in and diag_done <= all ones.
  - Otherwise go to SUB with lane = LANES-1.
- Each operation holds its inputs stable for ARITH_LAT+1 cycles. The result is captured at the edge ending the last cycle. The operation timer counts 0..ARITH_LAT.
- SUB: sub_a/sub_b = captured element/new_element lane l. Capture sub_y into delta[l]. Lanes are issued MSB-first. After lane 0, go to ADD with d=0, lane=LANES-1.
- ADD: add_a = captured diag d lane l, add_b = delta[l]. Capture add_y into new_diag[d][l].
  - On capture of lane 0, set diag_done[d].
  - Advance d. After d=NUM_DIAG-1, go to DONE.
- DONE: done=1, busy=0, for one cycle, then IDLE. new_diag holds until the next accepted start.
- start while not in IDLE (including DONE) is ignored.
- Latency from start edge t to done cycle:
  - normal: t + (LANES + NUM_DIAG*LANES)*(ARITH_LAT+1) + 1
  - fast path: t+1
  - defaults: done in cycle t+7
- Arithmetic: the block is transport only. Overflow and wrap are whatever the external units produce; no width growth.

Decomposition:
- Package arith_seq_pkg: state enum (IDLE, SUB, ADD, DONE), and lane/diag slice helper functions computing bit offsets from WORD_W/LANES.
- One sub-module: arith_op_timer (counts 0..ARITH_LAT, asserts last; sync reset, clear on issue).
- Everything else stays in arith_update_sequencer.

Test Plan:
- Defaults, combinational model. element={0x000010,0x000020}, new_element={0x000004,0x000008}, diag0={0x000100,0x000200}, diag1={0x000300,0x000400} -> new_diag0={0x00010C,0x000218}, new_diag1={0x00030C,0x000418}. done in cycle t+7; diag_done[0] rises at t+5, diag_done[1] at t+7.
- Fast path: element==new_element=0x123456_ABCDEF -> done at t+1, new_diag==diag_in, diag_done=2'b11, sub_a/add_a stay 0.
- ARITH_LAT=2, bench model registers output 2 cycles, same vectors as test 1 -> identical results. done at t+1+6*3 = t+19. Operands stable for 3 cycles each.
- Wrap: LANES=1, NUM_DIAG=3, diag={0xFFFFFF,0x000000,0x7FFFFF}, delta=+1 (element=0x000002, new_element=0x000001) -> {0x000000,0x000001,0x800000}.
- Reset asserted during ADD of diag 1 -> next cycle: all outputs 0, IDLE. A fresh start then completes normally.
- start pulsed during SUB and during DONE -> ignored, no change in results or timing. Captured inputs remain unaffected by input changes after acceptance.

Source files
------------

// File: rtl/arith_seq_pkg.sv
// arith_seq_pkg: shared state encoding and lane/diagonal slice offsets for the update sequencer
package arith_seq_pkg;
  typedef enum logic [1:0] {IDLE, SUB, ADD, DONE} state_t;
  function automatic int lane_off(input int word_w, input int l);
    return l * word_w;
  endfunction
  function automatic int diag_off(input int word_w, input int lanes, input int d, input int l);
    return (d * lanes + l) * word_w;
  endfunction
endpackage

// File: rtl/arith_op_timer.sv
// arith_op_timer: counts 0..ARITH_LAT for each issued arithmetic operation and flags its last cycle
module arith_op_timer #(
  parameter int ARITH_LAT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic last
);
  localparam int CW = $clog2(ARITH_LAT + 2);
  logic [CW-1:0] cnt;
  assign last = cnt == CW'(ARITH_LAT);
  always_ff @(posedge clock)
    if (reset || clear) cnt <= '0;
    else cnt <= last ? '0 : cnt + CW'(1);
endmodule

// File: rtl/arith_update_sequencer.sv
// arith_update_sequencer: sequences shared sub/add units to apply element deltas to every diagonal
module arith_update_sequencer
  import arith_seq_pkg::*;
#(
  parameter int WORD_W    = 24,
  parameter int LANES     = 2,
  parameter int NUM_DIAG  = 2,
  parameter int ARITH_LAT = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [LANES*WORD_W-1:0]          element,
  input  logic [LANES*WORD_W-1:0]          new_element,
  input  logic [NUM_DIAG*LANES*WORD_W-1:0] diag_in,
  output logic [WORD_W-1:0]                sub_a,
  output logic [WORD_W-1:0]                sub_b,
  input  logic [WORD_W-1:0]                sub_y,
  output logic [WORD_W-1:0]                add_a,
  output logic [WORD_W-1:0]                add_b,
  input  logic [WORD_W-1:0]                add_y,
  output logic [NUM_DIAG*LANES*WORD_W-1:0] new_diag,
  output logic [NUM_DIAG-1:0]              diag_done,
  output logic                             busy,
  output logic                             done
);
  localparam int EW = LANES * WORD_W;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int DW = NUM_DIAG > 1 ? $clog2(NUM_DIAG) : 1;
  state_t state, state_n;
  logic [LW-1:0] lane;
  logic [DW-1:0] dix;
  logic [EW-1:0] elem_q, new_q, delta;
  logic [NUM_DIAG*EW-1:0] diag_q;
  logic last, lane_end, diag_end, same;
  assign same = element == new_element;
  assign lane_end = lane == '0;
  assign diag_end = dix == DW'(NUM_DIAG - 1);
  arith_op_timer #(.ARITH_LAT(ARITH_LAT)) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(!busy),
    .last(last)
  );
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_comb begin
    busy = state == SUB || state == ADD;
    done = state == DONE;
    state_n = state == IDLE ? (start ? (same ? DONE : SUB) : IDLE)
            : state == SUB ? (last && lane_end ? ADD : SUB)
            : state == ADD ? (last && lane_end && diag_end ? DONE : ADD)
            : IDLE;
    sub_a = state == SUB ? elem_q[lane_off(WORD_W, int'(lane)) +: WORD_W] : '0;
    sub_b = state == SUB ? new_q[lane_off(WORD_W, int'(lane)) +: WORD_W] : '0;
    add_a = state == ADD ? diag_q[diag_off(WORD_W, LANES, int'(dix), int'(lane)) +: WORD_W] : '0;
    add_b = state == ADD ? delta[lane_off(WORD_W, int'(lane)) +: WORD_W] : '0;
  end
  always_ff @(posedge clock)
    if (reset) begin
      lane      <= '0;
      dix       <= '0;
      elem_q    <= '0;
      new_q     <= '0;
      delta     <= '0;
      diag_q    <= '0;
      new_diag  <= '0;
      diag_done <= '0;
    end else begin
      if (state == IDLE && start) begin
        elem_q    <= element;
        new_q     <= new_element;
        diag_q    <= diag_in;
        lane      <= LW'(LANES - 1);
        dix       <= '0;
        diag_done <= same ? '1 : '0;
        if (same) new_diag <= diag_in;
      end
      if (busy && last) lane <= lane_end ? LW'(LANES - 1) : lane - LW'(1);
      if (state == SUB && last) delta[lane_off(WORD_W, int'(lane)) +: WORD_W] <= sub_y;
      if (state == ADD && last) begin
        new_diag[diag_off(WORD_W, LANES, int'(dix), int'(lane)) +: WORD_W] <= add_y;
        if (lane_end) begin
          diag_done[dix] <= 1'b1;
          dix <= diag_end ? '0 : dix + DW'(1);
        end
      end
    end
endmodule
